// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, mouse command bytes, default timing and frame builder.
package ps2_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned FRAME_W  = 10;
    localparam int unsigned BITCNT_W = 4;
    localparam int unsigned RETRY_W  = 4;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_REQ       = 3'd2;
    localparam logic [2:0] ST_XFER      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_DISABLE  = 8'hF5;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    localparam int unsigned DEF_INHIBIT_CYCLES = 6500;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 975000;
    localparam int unsigned DEF_MAX_RETRIES    = 2;

    // Edge 10 carries the stop bit; edge 11 is the device ACK slot.
    localparam logic [3:0] LAST_DATA_EDGE = 4'd10;

    // {stop, odd parity, data}, sent LSB first.
    function automatic logic [9:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus falling-edge detect for one PS/2 pad.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pad_in,
    output logic level,
    output logic fall_c
);

    logic meta_q, meta_d;
    logic cur_q,  cur_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = pad_in;
        cur_d  = meta_q;
        prev_d = cur_q;
    end

    // Reset to the idle-high bus level so no edge is seen on reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b1;
            cur_q  <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            cur_q  <= cur_d;
            prev_q <= prev_d;
        end
    end

    assign level  = cur_q;
    assign fall_c = prev_q & ~cur_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with ACK check and timeout.
// Optional retry on NACK/timeout when PS2_TX_RETRY_EN is defined.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic clk_level, clk_fall_c;
    logic data_level, data_fall_c;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .pad_in (ps2_clk_in),
        .level  (clk_level),
        .fall_c (clk_fall_c)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .pad_in (ps2_data_in),
        .level  (data_level),
        .fall_c (data_fall_c)
    );

    logic [STATE_W-1:0]  state_q,  state_d;
    logic [FRAME_W-1:0]  frame_q,  frame_d;
    logic [INH_W-1:0]    inh_q,    inh_d;
    logic [TO_W-1:0]     to_q,     to_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [RETRY_W-1:0]  retry_q,  retry_d;
    logic                nack_q,   nack_d;
    logic                clk_oe_q, clk_oe_d;
    logic                data_oe_q, data_oe_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                err_q,    err_d;
    logic                timing_c, finish_c, fail_c;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        inh_d     = inh_q;
        to_d      = to_q;
        bitcnt_d  = bitcnt_q;
        retry_d   = retry_q;
        nack_d    = nack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        finish_c  = 1'b0;
        fail_c    = 1'b0;

        timing_c = (state_q == ST_REQ) || (state_q == ST_XFER) || (state_q == ST_WAIT_IDLE);
        if (timing_c) begin
            to_d = to_q + TO_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_d   = build_frame(tx_data);
                    retry_d   = '0;
                    nack_d    = 1'b0;
                    inh_d     = '0;
                    busy_d    = 1'b1;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                inh_d = inh_q + INH_W'(1);
                if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    to_d      = '0;
                    bitcnt_d  = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_XFER;
            end
            ST_XFER: begin
                if (clk_fall_c) begin
                    to_d     = '0;
                    bitcnt_d = bitcnt_q + BITCNT_W'(1);
                    if (bitcnt_q < LAST_DATA_EDGE) begin
                        data_oe_d = ~frame_q[bitcnt_q];
                    end else begin
                        nack_d    = data_level;
                        data_oe_d = 1'b0;
                        state_d   = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    finish_c = 1'b1;
                    fail_c   = nack_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A detected edge restarts the watchdog, so it cannot also expire this cycle.
        if (timing_c && !clk_fall_c && (to_q == TO_W'(TIMEOUT_CYCLES - 1))) begin
            finish_c = 1'b1;
            fail_c   = 1'b1;
        end

        if (finish_c) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (fail_c && RETRY_EN && (retry_q < RETRY_W'(MAX_RETRIES))) begin
                retry_d  = retry_q + RETRY_W'(1);
                inh_d    = '0;
                nack_d   = 1'b0;
                clk_oe_d = 1'b1;
                state_d  = ST_INHIBIT;
            end else begin
                done_d  = 1'b1;
                err_d   = fail_c;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            inh_q     <= '0;
            to_q      <= '0;
            bitcnt_q  <= '0;
            retry_q   <= '0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            inh_q     <= inh_d;
            to_q      <= to_d;
            bitcnt_q  <= bitcnt_d;
            retry_q   <= retry_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: behavioural PS/2 device with a per-bit scoreboard.
module tb_ps2_host_tx;

    localparam int unsigned INH = 20;
    localparam int unsigned TO  = 1000;
    localparam int unsigned MR  = 2;
    localparam int unsigned H   = 30;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 1 + MR;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_pad, ps2_data_pad;

    assign ps2_clk_pad  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_pad = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .MAX_RETRIES    (MR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .tx_data     (tx_data),
        .ps2_clk_in  (ps2_clk_pad),
        .ps2_data_in (ps2_data_pad),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    int   cyc = 0, done_cnt = 0, last_req = 0, last_done = 0, inh_run = 0, last_inh = 0;
    logic last_err = 1'b0, oe_at_done = 1'b0, prev_doe = 1'b0, prev_coe = 1'b0;

    // Event monitor: done pulses, request start cycle, clk_oe run length.
    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_doe <= ps2_data_oe;
        prev_coe <= ps2_clk_oe;
        if (ps2_data_oe === 1'b1 && prev_doe !== 1'b1) last_req <= cyc;
        if (ps2_clk_oe === 1'b1) inh_run <= inh_run + 1;
        else begin
            if (prev_coe === 1'b1) last_inh <= inh_run;
            inh_run <= 0;
        end
        if (done === 1'b1) begin
            done_cnt   <= done_cnt + 1;
            last_done  <= cyc;
            last_err   <= err;
            oe_at_done <= ps2_clk_oe | ps2_data_oe;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int attempts);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f = {1'b1, 1'((ones % 2) == 0), b};
        for (int a = 0; a < attempts; a++)
            for (int i = 0; i < 10; i++) exp_q.push_back(~f[i]);
        tx_data = b;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Device side of one frame: waits for the request, clocks 11 edges, optional ACK.
    task automatic dev_frame(input logic ack, input int poke_edge, input int rst_edge);
        int   n;
        logic busy_ok;
        logic abort;
        logic e_bit;
        busy_ok = 1'b1;
        abort   = 1'b0;
        n = 0;
        while (!(ps2_clk_pad === 1'b1 && ps2_data_pad === 1'b0) && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL req_wait: no request seen within %0d cycles", n);
            exp_q.delete();
            return;
        end
        for (int e = 1; e <= 11 && !abort; e++) begin
            if (e == 11) dev_data_low = ack;
            for (int i = 0; i < int'(H); i++) begin
                tick();
                busy_ok &= (busy === 1'b1);
            end
            dev_clk_low = 1'b1;
            for (int i = 0; i < int'(H) && !abort; i++) begin
                tick();
                if (e == poke_edge) begin
                    if (i == 8) begin tx_data = 8'h00; start = 1'b1; end
                    else start = 1'b0;
                end
                if (e == rst_edge && i == 8) rst = 1'b0;
                if (e == rst_edge && i == 9) begin
                    rst = 1'b1;
                    checks++;
                    if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
                        errors++;
                        $display("FAIL rst_mid: clk_oe/data_oe/busy=%b required 000",
                                 {ps2_clk_oe, ps2_data_oe, busy});
                    end
                    abort = 1'b1;
                end
                if (!abort) busy_ok &= (busy === 1'b1);
            end
            if (!abort && e <= 10) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bit_edge%0d: scoreboard empty", e);
                end else begin
                    e_bit = exp_q.pop_front();
                    if (ps2_data_oe !== e_bit) begin
                        errors++;
                        $display("FAIL bit_edge%0d: data_oe=%b required %b", e, ps2_data_oe, e_bit);
                    end
                end
            end
            dev_clk_low = 1'b0;
        end
        repeat (5) tick();
        dev_data_low = 1'b0;
        if (abort) begin
            exp_q.delete();
        end else begin
            checks++;
            if (busy_ok !== 1'b1) begin
                errors++;
                $display("FAIL busy_frame: busy dropped during frame, required 1");
            end
        end
    endtask

    task automatic wait_done(input int d0, input int budget, input logic exp_err, input string name);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done: no done within %0d cycles", name, budget);
            return;
        end
        checks++;
        if (last_err !== exp_err) begin
            errors++;
            $display("FAIL %s_err: err=%b required %b", name, last_err, exp_err);
        end
        repeat (20) tick();
        checks++;
        if (done_cnt != d0 + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_single: done count=%0d busy=%b required 1 and 0",
                     name, done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        tx_data = 8'hFF;
        repeat (3) tick();
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy, done, err} !== 5'b00000) begin
            errors++;
            $display("FAIL reset: outputs=%b required 00000", {ps2_clk_oe, ps2_data_oe, busy, done, err});
        end
        rst = 1'b1;
        start = 1'b0;
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_start: busy=%b clk_oe=%b required 0 0", busy, ps2_clk_oe);
        end
    endtask

    task automatic test_enable();
        int d0;
        d0 = done_cnt;
        send(8'hF4, 1);
        dev_frame(1'b1, 0, 0);
        wait_done(d0, 500, 1'b0, "enable");
    endtask

    task automatic test_inhibit();
        int d0;
        d0 = done_cnt;
        send(8'hFF, 1);
        dev_frame(1'b1, 0, 0);
        wait_done(d0, 500, 1'b0, "inhibit");
        checks++;
        if (last_inh != int'(INH)) begin
            errors++;
            $display("FAIL inhibit_len: clk_oe high %0d cycles required %0d", last_inh, INH);
        end
    endtask

    task automatic test_nack();
        int d0;
        d0 = done_cnt;
        send(8'hF3, ATTEMPTS);
        for (int a = 0; a < ATTEMPTS; a++) dev_frame(1'b0, 0, 0);
        wait_done(d0, 500, 1'b1, "nack");
    endtask

    task automatic test_timeout();
        int d0;
        d0 = done_cnt;
        send(8'hF5, 0);
        wait_done(d0, ATTEMPTS * int'(INH + TO + 100), 1'b1, "timeout");
        checks++;
        if (last_done - last_req != int'(TO) || oe_at_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cycle: done %0d cycles after request oe=%b required %0d and 0",
                     last_done - last_req, oe_at_done, TO);
        end
    endtask

    task automatic test_ignored_start();
        int d0;
        d0 = done_cnt;
        send(8'hF3, 1);
        dev_frame(1'b1, 5, 0);
        wait_done(d0, 500, 1'b0, "ignore");
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        send(8'hF4, 1);
        dev_frame(1'b1, 0, 5);
        repeat (50) tick();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_nodone: done count=%0d busy=%b required 0 0", done_cnt - d0, busy);
        end
        d0 = done_cnt;
        send(8'hF4, 1);
        dev_frame(1'b1, 0, 0);
        wait_done(d0, 500, 1'b0, "after_rst");
    endtask

    initial begin
        start = 1'b0;
        tx_data = 8'h00;
        test_reset();
        test_enable();
        test_inhibit();
        test_nack();
        test_timeout();
        test_ignored_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the mouse over the same ps2_clk/ps2_data lines the mouse receiver listens on, e.g. 0xFF reset, 0xF4 enable reporting, 0xF3 set sample rate.
- Implements the host request-to-send sequence, shifts out data, parity and stop bits on device clock edges, and checks the device ACK bit.
- Sits beside the mouse controller in the 65 MHz domain. The top level ties the open-drain enables to the inout pads.

Parameters:
- INHIBIT_CYCLES, 6500: clk cycles ps2_clk is held low before the request (100 us at 65 MHz).
- TIMEOUT_CYCLES, 975000: max clk cycles between device falling edges before abort (15 ms).
- MAX_RETRIES, 2: extra attempts on NACK or timeout; used only with PS2_TX_RETRY_EN.

Ports:
- clk  in  1  system clock, 65 MHz.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to send tx_data; sampled only in IDLE.
- tx_data  in  8  command byte, latched on accepted start.
- ps2_clk_in  in  1  pad level of ps2_clk, asynchronous.
- ps2_data_in  in  1  pad level of ps2_data, asynchronous.
- ps2_clk_oe  out  1  1 = drive ps2_clk low, 0 = release (Z).
- ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release (Z).
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of a transaction.
- err  out  1  one-cycle pulse coincident with done on NACK or timeout.

Behaviour:
- Reset (rst low at a clk edge), next cycle:
  - all outputs 0, FSM in IDLE, counters cleared, lines released.
  - Reset mid-transaction aborts immediately with no done pulse.
  - Reset wins over a simultaneous start.
- Input synchronization: 2-FF synchronizers on both pad inputs. A falling edge of ps2_clk is sync_prev=1 and sync_cur=0; it is detected 3 cycles after the pad edge.
- IDLE:
  - start=1 latches tx_data.
  - Builds frame[9:0] = {stop=1, parity=~^tx_data, tx_data}.
  - busy goes 1 the next cycle; go to INHIBIT.
  - start while busy is ignored; no queue.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ: data_oe=1 (start bit 0), clk_oe=0. Edge counter bitcnt=0. Go to XFER.
- XFER: on each device falling edge, bitcnt increments.
  - Edges 1..10 present frame[bitcnt-1] as data_oe = ~bit on the cycle after detection.
  - Edge 10 presents the stop bit, which releases data.
  - Edge 11 samples synced data as the ACK: 0 = ACK, 1 = NACK. Go to WAIT_IDLE.
- WAIT_IDLE: both lines released. Wait until synced clk=1 and data=1, then go to DONE.
- DONE: pulse done, plus err if NACK. busy=0 in the same cycle. Return to IDLE.
- Timeout (REQ, XFER, WAIT_IDLE):
  - The counter resets on every detected falling edge.
  - Reaching TIMEOUT_CYCLES releases both lines and goes to DONE with err=1.
- Parity is odd over the 8 data bits; width-exact 8-bit XOR reduction.
- bitcnt is 4 bits and never wraps; an edge beyond 11 cannot occur outside XFER.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: on NACK or timeout, if retry count < MAX_RETRIES:
  - increment the count and re-enter INHIBIT with the same latched frame;
  - no done pulse, busy stays 1.
  - After the final failed attempt: done+err.
  - Retry count clears on accepted start.
- Undefined: first NACK or timeout ends with done+err; MAX_RETRIES is unused.

Decomposition:
- Shared package ps2_pkg:
  - FSM state encoding (IDLE, INHIBIT, REQ, XFER, WAIT_IDLE, DONE);
  - command constants CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_DISABLE=8'hF5, CMD_SET_RATE=8'hF3;
  - ACK_BYTE=8'hFA;
  - default timing counts.
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detector, one instance per line. The mouse receiver can reuse it.

Test Plan:
- tx_data=8'hF4, device model clocks at 12 kHz and ACKs:
  - data_oe pattern after edges 1..9 = bits 0,0,1,0,1,1,1,1 and parity 0;
  - released at edge 10;
  - done=1, err=0; busy high for the whole frame.
- tx_data=8'hFF with INHIBIT_CYCLES=20: clk_oe high exactly 20 cycles; parity bit 1; done without err.
- Device leaves data high at edge 11 (NACK): done=1, err=1. With PS2_TX_RETRY_EN: 3 full frames, then a single done+err.
- No device clocks after REQ, TIMEOUT_CYCLES=1000: both oe drop to 0 and done+err pulse at cycle 1000 after the last edge.
- start pulsed during XFER with tx_data=8'h00: ignored, frame bits unchanged, single done.
- rst low during XFER edge 5: next cycle clk_oe=data_oe=busy=0, no done. A new start afterwards completes normally.
